bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 159 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// Optional registered seven-segment output is enabled by defining SEVEN_SEG_EN.
module bin_to_bcd_seq #(
  parameter int WORD_LENGTH = 8,
  parameter int DIGITS      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WORD_LENGTH-1:0]   data_in,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [4*DIGITS-1:0]      bcd_out,
`ifdef SEVEN_SEG_EN
  output logic [7*DIGITS-1:0]      seg_out,
`endif
  output logic [1:0]               dbg_state
);

  localparam int CNT_W = $clog2(WORD_LENGTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  // Handshake: start is a level request honoured only in S_IDLE (no queuing);
  // busy is high for exactly WORD_LENGTH cycles, then done pulses for one cycle
  // in the same cycle bcd_out first shows the new result.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BCD_W-1:0]       adj;
  logic                   last_bit;

  // Double-dabble correction: any digit >= 5 becomes >= 8 so the shift carries.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

`ifdef SEVEN_SEG_EN
  logic [7*DIGITS-1:0] seg_q, seg_d;

  // Active-low segments ordered {g,f,e,d,c,b,a}; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] seg_all(input logic [BCD_W-1:0] b);
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = seg7(b[4*i +: 4]);
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_ZERO = {DIGITS{7'b1000000}};
`endif

  assign adj      = add3_digits(scratch_q);
  assign last_bit = (cnt_q == CNT_W'(WORD_LENGTH - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef SEVEN_SEG_EN
    seg_d     = seg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = data_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        scratch_d = {adj[BCD_W-2:0], shift_q[WORD_LENGTH-1]};
        shift_d   = {shift_q[WORD_LENGTH-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        // The final shifted scratch is the result; publish it as we leave.
        if (last_bit) begin
          bcd_d   = scratch_d;
`ifdef SEVEN_SEG_EN
          seg_d   = seg_all(scratch_d);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
`ifdef SEVEN_SEG_EN
      seg_q     <= SEG_ZERO;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
`ifdef SEVEN_SEG_EN
      seg_q     <= seg_d;
`endif
    end
  end

  assign busy      = (state_q == S_CONVERT);
  assign done      = (state_q == S_DONE);
  assign bcd_out   = bcd_q;
  assign dbg_state = state_q;
`ifdef SEVEN_SEG_EN
  assign seg_out   = seg_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table, timing, held start,
// reset abort, optional seven-segment output and a full 0..255 sweep.
module tb_bin_to_bcd_seq;

  localparam int WL = 8;
  localparam int DG = 3;

  logic          clk;
  logic          reset;
  logic [WL-1:0] data_in;
  logic          start;
  logic          busy;
  logic          done;
  logic [11:0]   bcd_out;
  logic [1:0]    dbg_state;
`ifdef SEVEN_SEG_EN
  logic [20:0]   seg_out;
`endif

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  bin_to_bcd_seq #(.WORD_LENGTH(WL), .DIGITS(DG)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
`ifdef SEVEN_SEG_EN
    .seg_out   (seg_out),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0]  din;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent decimal model used for the sweep.
  function automatic logic [11:0] dec_model(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called just after the edge that samples start. The sampling edge counts
  // as edge 1, so done is expected on the 9th edge with busy seen 8 times.
  task automatic wait_done(input logic clr_start, input logic use_mid,
                           input logic [7:0] mid_val, output logic [11:0] res,
                           output int busy_cnt, output int done_edge);
    int edges;
    logic fin;
    edges     = 1;
    busy_cnt  = 0;
    done_edge = 0;
    res       = '0;
    fin       = 1'b0;
    @(negedge clk);
    if (clr_start) start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!fin) begin
        if (busy && done) overlap++;
        if (busy) busy_cnt++;
        if (use_mid && k == 3) data_in = mid_val;
        if (done) begin
          done_edge = edges;
          res       = bcd_out;
          fin       = 1'b1;
        end else begin
          @(posedge clk);
          edges++;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic convert(input logic [7:0] val, output logic [11:0] res,
                         output int busy_cnt, output int done_edge);
    @(negedge clk);
    data_in = val;
    start   = 1'b1;
    @(posedge clk);
    wait_done(1'b1, 1'b0, 8'h00, res, busy_cnt, done_edge);
  endtask

  initial begin
    logic [11:0] res;
    int bc, de, seen;

    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;

    vecs[0]  = '{8'd225, 12'h225};
    vecs[1]  = '{8'd0,   12'h000};
    vecs[2]  = '{8'd255, 12'h255};
    vecs[3]  = '{8'd99,  12'h099};
    vecs[4]  = '{8'd108, 12'h108};
    vecs[5]  = '{8'd1,   12'h001};
    vecs[6]  = '{8'd9,   12'h009};
    vecs[7]  = '{8'd10,  12'h010};
    vecs[8]  = '{8'd100, 12'h100};
    vecs[9]  = '{8'd199, 12'h199};
    vecs[10] = '{8'd5,   12'h005};
    vecs[11] = '{8'd50,  12'h050};

    do_reset();
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_bcd",   32'(bcd_out),   32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef SEVEN_SEG_EN
    check("rst_seg", 32'(seg_out), 32'({7'b1000000, 7'b1000000, 7'b1000000}));
`endif

    // Vector table: value, busy length and done latency.
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].din, res, bc, de);
      check($sformatf("vec%0d_bcd", i),  32'(res), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_busy", i), 32'(bc),  32'd8);
      check($sformatf("vec%0d_edge", i), 32'(de),  32'd9);
`ifdef SEVEN_SEG_EN
      if (vecs[i].din == 8'd108)
        check("seg_108", 32'(seg_out), 32'({7'b1111001, 7'b1000000, 7'b0000000}));
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_drop", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(dbg_state), 32'd0);
    end

    // Idle with start low holds everything (last vector was 50).
    repeat (3) @(negedge clk);
    check("idle_hold_bcd",  32'(bcd_out), 32'h050);
    check("idle_hold_busy", 32'(busy),    32'd0);
    check("idle_hold_done", 32'(done),    32'd0);

    // Start held high; data_in changes mid-conversion.
    @(negedge clk);
    data_in = 8'd37;
    start   = 1'b1;
    @(posedge clk);
    wait_done(1'b0, 1'b1, 8'd200, res, bc, de);
    check("hold_bcd",  32'(res), 32'h037);
    check("hold_edge", 32'(de),  32'd9);
    @(negedge clk);
    check("hold_idle_state", 32'(dbg_state), 32'd0);
    check("hold_idle_busy",  32'(busy),      32'd0);
    @(posedge clk);
    wait_done(1'b1, 1'b0, 8'h00, res, bc, de);
    check("hold2_busy", 32'(bc),  32'd8);
    check("hold2_bcd",  32'(res), 32'h200);

    // Reset in the 4th CONVERT cycle of 99 aborts without a done pulse.
    @(negedge clk);
    data_in = 8'd99;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", 32'(busy),    32'd1);
    check("abort_bcd_hold", 32'(bcd_out), 32'h200);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_bcd",   32'(bcd_out),   32'h0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Reset has priority over start.
    @(negedge clk);
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 8'd77;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_prio_state", 32'(dbg_state), 32'd0);

    // Exhaustive sweep against the decimal model.
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), res, bc, de);
      check($sformatf("sweep_%0d", v), 32'(res), 32'(dec_model(v)));
    end

    check("no_busy_done_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
